fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the single-issue MIPS pipeline. It holds the PC and requests instructions from instruction memory over a req/ack handshake. It registers each returned word into IF/ID and presents the opcode field directly to the main control decoder in ID. It absorbs hazard stalls through a one-entry hold buffer and services taken-branch redirects by flushing IF/ID.

---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory handshake, hazard/redirect controls and IF/ID outputs of the fetch stage
//   imem_req/imem_addr      fetch request and address (fetch unit -> memory)
//   imem_ack/imem_rdata     response and instruction word (memory -> fetch unit)
//   stall/redirect/redirect_pc  hazard hold and taken-branch redirect (pipeline -> fetch unit)
//   id_valid/id_instr/id_pc4/op IF/ID register contents and opcode (fetch unit -> ID)
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [5:0]  op;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc4, op,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc4, op,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction fetch over req/ack, one-entry stall hold buffer and IF/ID register
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master (memory handshake, stall/redirect in, IF/ID and op out)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    bus
);
    typedef enum logic [1:0] {RST, FETCH, HOLD} fetchStateT;

    fetchStateT  state, nextState;
    logic [31:0] pc, nextPc;
    logic [31:0] bufInstr, nextBufInstr;
    logic [31:0] bufPc4, nextBufPc4;
    logic        idValid, nextIdValid;
    logic [31:0] idInstr, nextIdInstr;
    logic [31:0] idPc4, nextIdPc4;
    logic [31:0] pcPlus4;
    logic [31:0] redirectTarget;

    assign pcPlus4        = pc + 32'd4;
    assign redirectTarget = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST;
            pc       <= RESET_PC;
            bufInstr <= '0;
            bufPc4   <= '0;
            idValid  <= 1'b0;
            idInstr  <= '0;
            idPc4    <= '0;
        end else begin
            state    <= nextState;
            pc       <= nextPc;
            bufInstr <= nextBufInstr;
            bufPc4   <= nextBufPc4;
            idValid  <= nextIdValid;
            idInstr  <= nextIdInstr;
            idPc4    <= nextIdPc4;
        end
    end

    always_comb begin
        nextState    = state;
        nextPc       = pc;
        nextBufInstr = bufInstr;
        nextBufPc4   = bufPc4;
        nextIdValid  = idValid;
        nextIdInstr  = idInstr;
        nextIdPc4    = idPc4;
        case (state)
            RST: nextState = FETCH;
            FETCH: begin
                if (bus.redirect) begin
                    nextPc      = redirectTarget;
                    nextIdValid = 1'b0;
                    nextIdInstr = '0;
                    nextIdPc4   = '0;
                end else if (bus.imem_ack && !bus.stall) begin
                    nextIdValid = 1'b1;
                    nextIdInstr = bus.imem_rdata;
                    nextIdPc4   = pcPlus4;
                    nextPc      = pcPlus4;
                end else if (bus.imem_ack) begin
                    // ID cannot take the word yet; park it so the fetch is not repeated
                    nextBufInstr = bus.imem_rdata;
                    nextBufPc4   = pcPlus4;
                    nextState    = HOLD;
                end else if (!bus.stall) begin
                    nextIdValid = 1'b0;
                    nextIdInstr = '0;
                    nextIdPc4   = '0;
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    nextPc       = redirectTarget;
                    nextBufInstr = '0;
                    nextBufPc4   = '0;
                    nextIdValid  = 1'b0;
                    nextIdInstr  = '0;
                    nextIdPc4    = '0;
                    nextState    = FETCH;
                end else if (!bus.stall) begin
                    nextIdValid = 1'b1;
                    nextIdInstr = bufInstr;
                    nextIdPc4   = bufPc4;
                    nextPc      = pcPlus4;
                    nextState   = FETCH;
                end
            end
            default: nextState = RST;
        endcase
    end

    assign bus.imem_req  = state == FETCH;
    assign bus.imem_addr = pc;
    assign bus.id_valid  = idValid;
    assign bus.id_instr  = idInstr;
    assign bus.id_pc4    = idPc4;
    assign bus.op        = idInstr[31:26];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard-driven checks of fetch, bubbles, stall hold, redirect, PC wrap and async reset
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef logic [103:0] snapT;

    int   checks = 0;
    int   errors = 0;
    snapT q[$];
    snapT e;

    int          mState;
    logic [31:0] mPc, mBuf, mBufPc4, mInstr, mPc4;
    logic        mValid;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h0) ? 32'h8C41_0004 : {a[7:2] ^ 6'h2A, a[27:2]};
    endfunction

    function automatic snapT observed();
        return {bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_instr, bus.id_pc4, bus.op};
    endfunction

    function automatic snapT expected();
        return {mState == 1, mPc, mValid, mInstr, mPc4, mInstr[31:26]};
    endfunction

    task automatic flushModel();
        mValid = 1'b0;
        mInstr = '0;
        mPc4   = '0;
    endtask

    task automatic resetModel();
        mState  = 0;
        mPc     = '0;
        mBuf    = '0;
        mBufPc4 = '0;
        flushModel();
        q.delete();
    endtask

    task automatic applyReset();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        rst_n = 1'b0;
        #1;
        resetModel();
    endtask

    task automatic releaseReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // one clock: drive inputs, advance the reference model, queue the expected post-edge view
    task automatic drive(input logic ack, input logic stl, input logic rd, input logic [31:0] rpc);
        bus.imem_ack    = ack;
        bus.stall       = stl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.imem_rdata  = ack ? memWord(bus.imem_addr) : 32'hDEAD_BEEF;
        if (mState == 0) begin
            mState = 1;
        end else if (mState == 1) begin
            if (rd) begin
                mPc = {rpc[31:2], 2'b00};
                flushModel();
            end else if (ack && !stl) begin
                mInstr = memWord(mPc);
                mPc4   = mPc + 32'd4;
                mValid = 1'b1;
                mPc    = mPc + 32'd4;
            end else if (ack) begin
                mBuf    = memWord(mPc);
                mBufPc4 = mPc + 32'd4;
                mState  = 2;
            end else if (!stl) begin
                flushModel();
            end
        end else begin
            if (rd) begin
                flushModel();
                mBuf    = '0;
                mBufPc4 = '0;
                mPc     = {rpc[31:2], 2'b00};
                mState  = 1;
            end else if (!stl) begin
                mInstr = mBuf;
                mPc4   = mBufPc4;
                mValid = 1'b1;
                mPc    = mPc + 32'd4;
                mState = 1;
            end
        end
        q.push_back(expected());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++;
        if (observed() !== expected()) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", observed(), expected());
        end
        releaseReset();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL stream[%0d]: got %h expected %h", i, observed(), e);
            end
            checks++;
            if (bus.imem_addr !== 32'(4 * i)) begin
                errors++;
                $display("FAIL stream_addr[%0d]: got %h expected %h", i, bus.imem_addr, 32'(4 * i));
            end
            if (i == 1) begin
                checks++;
                if (bus.op !== 6'b100011) begin
                    errors++;
                    $display("FAIL lw_opcode: got %b expected 100011", bus.op);
                end
            end
        end
    endtask

    task automatic test_slow_ack();
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                drive(j == 2, 1'b0, 1'b0, '0);
                e = q.pop_front();
                checks++;
                if (observed() !== e) begin
                    errors++;
                    $display("FAIL slow_ack[%0d.%0d]: got %h expected %h", k, j, observed(), e);
                end
                checks++;
                if (bus.imem_addr !== 32'h14 + 32'(4 * k) + ((j == 2) ? 32'd4 : 32'd0)) begin
                    errors++;
                    $display("FAIL slow_ack_addr[%0d.%0d]: got %h", k, j, bus.imem_addr);
                end
            end
        end
    endtask

    task automatic test_stall();
        applyReset();
        releaseReset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL stall_pre[%0d]: got %h expected %h", i, observed(), e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i < 3, 1'b0, '0);
            e = q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL stall_seq[%0d]: got %h expected %h", i, observed(), e);
            end
            if (i < 3) begin
                checks++;
                if (bus.imem_req !== 1'b0 || bus.id_instr !== memWord(32'hC)) begin
                    errors++;
                    $display("FAIL stall_hold[%0d]: req %b instr %h expected req 0 instr %h", i, bus.imem_req, bus.id_instr, memWord(32'hC));
                end
            end
        end
        checks++;
        if (bus.id_instr !== memWord(32'h10) || bus.imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL stall_release: instr %h addr %h expected %h 00000014", bus.id_instr, bus.imem_addr, memWord(32'h10));
        end
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 1'b1, 32'h42);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL redirect_fetch: got %h expected %h", observed(), e);
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        e = q.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL redirect_enter_hold: got %h expected %h", observed(), e);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h42);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.id_valid !== 1'b0 || bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL redirect_hold: got %h expected %h", observed(), e);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.id_instr !== memWord(32'h40) || bus.id_pc4 !== 32'h44) begin
            errors++;
            $display("FAIL redirect_refetch: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: got %h expected %h", observed(), e);
        end
        drive(1'b1, 1'b0, 1'b0, '0);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.imem_addr !== 32'h0 || bus.id_pc4 !== 32'h0 || bus.id_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1'b0, 1'b0, 1'b1, 32'h20);
        e = q.pop_front();
        drive(1'b1, 1'b1, 1'b0, '0);
        e = q.pop_front();
        checks++;
        if (observed() !== e || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL hold_before_reset: got %h expected %h", observed(), e);
        end
        #2;
        applyReset();
        checks++;
        if (observed() !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 6'h0}) begin
            errors++;
            $display("FAIL reset_in_hold: got %h expected all zero", observed());
        end
        releaseReset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = q.pop_front();
            checks++;
            if (observed() !== e || (bus.id_valid && bus.id_instr === memWord(32'h20))) begin
                errors++;
                $display("FAIL restart[%0d]: got %h expected %h", i, observed(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
            e = q.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, observed(), e);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_stream();
        test_slow_ack();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_in_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end
endmodule
